// File: rtl/dct_ctrl_pkg.sv
// Shared constants and types for the DCT block scheduler and its ping-pong buffer.
package dct_ctrl_pkg;

    localparam int unsigned BLK_PIX    = 64;
    localparam int unsigned PIX_W      = 8;
    localparam int unsigned IDX_W      = $clog2(BLK_PIX);
    localparam int unsigned COEF_CNT_W = 7;

    typedef enum logic [1:0] {
        D_IDLE,
        D_START,
        D_FEED,
        D_WAIT
    } drain_state_t;

    // One-hot bank select used for the full-flag set/clear strobes.
    function automatic logic [1:0] bank_mask(input logic bank);
        return bank ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/block_pingpong_buf.sv
// Two-bank 64x8 block store with a registered read port and per-bank full flags.
module block_pingpong_buf
    import dct_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             wr_bank,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             re,
    input  logic             rd_bank,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [PIX_W-1:0] rd_data,
    input  logic [1:0]       full_set,
    input  logic [1:0]       full_clr,
    output logic [1:0]       full
);

    logic [PIX_W-1:0] mem [2][BLK_PIX];

    // Storage is not reset; a bank is only read after it has been completely written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_bank][wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[rd_bank][rd_idx];
        end
    end

    // Set and clear never target the same bank: fill only writes an empty bank, drain only releases a full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
        end else begin
            full <= (full & ~full_clr) | full_set;
        end
    end

endmodule

// File: rtl/dct_block_scheduler.sv
// Frame sequencer: buffers incoming 8x8 blocks in ping-pong banks and feeds them to the 2-D DCT engine.
module dct_block_scheduler
    import dct_ctrl_pkg::*;
#(
    parameter int unsigned NB_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [NB_W-1:0]  cfg_num_blocks,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             pix_ready,
    output logic             eng_start,
    output logic [PIX_W-1:0] eng_pixel,
    input  logic             eng_valid_out,
    input  logic             eng_done,
    output logic [NB_W-1:0]  blk_idx,
    output logic             busy,
    output logic             frame_done,
    output logic             err
);

    localparam int unsigned      CT_W     = COEF_CNT_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_PIX - 1);

    logic [NB_W-1:0]       cfg_blks;
    logic [NB_W-1:0]       accepted_blks;
    logic [NB_W-1:0]       done_blks;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [COEF_CNT_W-1:0] coef_cnt;
    logic [1:0]            full;
    drain_state_t          state;
    drain_state_t          state_nxt;

    logic                  frame_acc_c;
    logic                  pix_fire_c;
    logic                  blk_filled_c;
    logic                  rd_en_c;
    logic [IDX_W-1:0]      rd_addr_c;
    logic                  blk_release_c;
    logic                  last_blk_c;
    logic                  err_set_c;
    logic [CT_W-1:0]       coef_total_c;
    logic [1:0]            full_set_c;
    logic [1:0]            full_clr_c;

    assign frame_acc_c  = frame_start & ~busy;
    assign pix_ready    = busy & ~full[wr_bank] & (accepted_blks < cfg_blks);
    assign pix_fire_c   = pix_valid & pix_ready;
    assign blk_filled_c = pix_fire_c & (wr_idx == LAST_IDX);
    assign full_set_c   = blk_filled_c  ? bank_mask(wr_bank) : 2'b00;
    assign full_clr_c   = blk_release_c ? bank_mask(rd_bank) : 2'b00;
    assign last_blk_c   = (done_blks + NB_W'(1)) == cfg_blks;

    // A valid arriving together with done still counts toward the block's coefficient total.
    assign coef_total_c = CT_W'(coef_cnt) + CT_W'(eng_valid_out);
    assign err_set_c    = (blk_release_c & (coef_total_c != CT_W'(BLK_PIX)))
                        | ((state != D_WAIT) & (eng_done | eng_valid_out));

    block_pingpong_buf u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (pix_fire_c),
        .wr_bank  (wr_bank),
        .wr_idx   (wr_idx),
        .wr_data  (pix_data),
        .re       (rd_en_c),
        .rd_bank  (rd_bank),
        .rd_idx   (rd_addr_c),
        .rd_data  (eng_pixel),
        .full_set (full_set_c),
        .full_clr (full_clr_c),
        .full     (full)
    );

    // Fill side: write pointer and bank toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx  <= '0;
            wr_bank <= 1'b0;
        end else if (pix_fire_c) begin
            wr_idx <= wr_idx + IDX_W'(1);
            if (blk_filled_c) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= D_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Drain FSM; the read address runs one ahead because the buffer read port is registered.
    always_comb begin
        state_nxt     = state;
        rd_en_c       = 1'b0;
        rd_addr_c     = '0;
        blk_release_c = 1'b0;
        case (state)
            D_IDLE: begin
                if (busy && full[rd_bank]) begin
                    state_nxt = D_START;
                end
            end
            D_START: begin
                rd_en_c   = 1'b1;
                state_nxt = D_FEED;
            end
            D_FEED: begin
                if (rd_idx == LAST_IDX) begin
                    state_nxt = D_WAIT;
                end else begin
                    rd_en_c   = 1'b1;
                    rd_addr_c = rd_idx + IDX_W'(1);
                end
            end
            D_WAIT: begin
                if (eng_done) begin
                    blk_release_c = 1'b1;
                    state_nxt     = D_IDLE;
                end
            end
            default: state_nxt = D_IDLE;
        endcase
    end

    // Drain datapath: feed index, coefficient counter, read bank and start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx    <= '0;
            coef_cnt  <= '0;
            rd_bank   <= 1'b0;
            eng_start <= 1'b0;
        end else begin
            eng_start <= (state_nxt == D_START);
            if (state == D_START) begin
                rd_idx <= '0;
            end else if (state == D_FEED) begin
                rd_idx <= rd_idx + IDX_W'(1);
            end
            if (state == D_START) begin
                coef_cnt <= '0;
            end else if ((state == D_WAIT) && eng_valid_out && !eng_done && (coef_cnt != '1)) begin
                coef_cnt <= coef_cnt + COEF_CNT_W'(1);
            end
            if (blk_release_c) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Frame bookkeeping and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_blks      <= '0;
            accepted_blks <= '0;
            done_blks     <= '0;
            blk_idx       <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            err           <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err        <= (err & ~frame_acc_c) | err_set_c;
            if (frame_acc_c) begin
                cfg_blks      <= cfg_num_blocks;
                accepted_blks <= '0;
                done_blks     <= '0;
                blk_idx       <= '0;
                busy          <= (cfg_num_blocks != '0);
                frame_done    <= (cfg_num_blocks == '0);
            end else begin
                if (blk_filled_c) begin
                    accepted_blks <= accepted_blks + NB_W'(1);
                end
                if (blk_release_c) begin
                    done_blks <= done_blks + NB_W'(1);
                    blk_idx   <= blk_idx + NB_W'(1);
                    if (last_blk_c) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dct_block_scheduler.sv
// Self-checking bench for dct_block_scheduler with a behavioural engine and pixel-stream scoreboard.
module tb_dct_block_scheduler;

    localparam int unsigned NB_W = 16;
    localparam int TMO = 3000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            frame_start = 1'b0;
    logic [NB_W-1:0] cfg_num_blocks = '0;
    logic            pix_valid = 1'b0;
    logic [7:0]      pix_data = 8'h00;
    logic            pix_ready;
    logic            eng_start;
    logic [7:0]      eng_pixel;
    logic            eng_valid_out = 1'b0;
    logic            eng_done = 1'b0;
    logic [NB_W-1:0] blk_idx;
    logic            busy;
    logic            frame_done;
    logic            err;

    dct_block_scheduler #(.NB_W(NB_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_start    (frame_start),
        .cfg_num_blocks (cfg_num_blocks),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .pix_ready      (pix_ready),
        .eng_start      (eng_start),
        .eng_pixel      (eng_pixel),
        .eng_valid_out  (eng_valid_out),
        .eng_done       (eng_done),
        .blk_idx        (blk_idx),
        .busy           (busy),
        .frame_done     (frame_done),
        .err            (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Observation logs (cycle stamps) and the expected pixel stream in handshake order.
    int              hs_cyc[$];
    int              start_cyc[$];
    logic [NB_W-1:0] start_blk[$];
    int              done_cyc[$];
    int              fd_cyc[$];
    logic            busy_at_fd[$];
    logic [7:0]      exp_q[$];
    bit              ready_seen = 0;
    bit              busy_seen = 0;
    int              pix_err = 0;
    int              pix_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pix_valid && pix_ready) begin
                hs_cyc.push_back(cyc);
                exp_q.push_back(pix_data);
            end
            if (pix_ready) ready_seen = 1;
            if (busy) busy_seen = 1;
            if (eng_start) begin
                start_cyc.push_back(cyc);
                start_blk.push_back(blk_idx);
            end
            if (eng_done) done_cyc.push_back(cyc);
            if (frame_done) begin
                fd_cyc.push_back(cyc);
                busy_at_fd.push_back(busy);
            end
        end
    end

    // Engine model: takes 64 pixels right after start, waits, returns eng_ncoef valids, then done.
    int         eng_lat_min = 20;
    int         eng_lat_max = 40;
    int         eng_ncoef = 64;
    int         e_phase = 0;
    int         e_k = 0;
    int         e_cnt = 0;
    int         e_n = 0;
    logic [7:0] e_exp;

    always @(posedge clk) begin
        #1;
        eng_valid_out = 1'b0;
        eng_done      = 1'b0;
        if (!rst_n) begin
            e_phase = 0;
        end else begin
            case (e_phase)
                0: if (eng_start) begin
                    e_phase = 1;
                    e_k = 0;
                end
                1: begin
                    if (exp_q.size() == 0) begin
                        pix_err++;
                    end else begin
                        e_exp = exp_q.pop_front();
                        if (eng_pixel !== e_exp) pix_err++;
                    end
                    pix_cnt++;
                    e_k++;
                    if (e_k == 64) begin
                        e_phase = 2;
                        e_cnt = int'($urandom_range(eng_lat_max, eng_lat_min));
                    end
                end
                2: if (e_cnt == 0) begin
                    e_phase = 3;
                    e_n = 0;
                end else begin
                    e_cnt--;
                end
                default: if (e_n < eng_ncoef) begin
                    eng_valid_out = 1'b1;
                    e_n++;
                end else begin
                    eng_done = 1'b1;
                    e_phase = 0;
                end
            endcase
        end
    end

    task automatic clear_logs();
        hs_cyc.delete();
        start_cyc.delete();
        start_blk.delete();
        done_cyc.delete();
        fd_cyc.delete();
        busy_at_fd.delete();
        exp_q.delete();
        ready_seen = 0;
        busy_seen = 0;
        pix_err = 0;
        pix_cnt = 0;
    endtask

    task automatic start_frame(input int cfg, output int fcyc);
        frame_start = 1'b1;
        cfg_num_blocks = NB_W'(cfg);
        fcyc = cyc;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic send_pixels(input int n, input bit ramp, input int gap_pct, input string tag);
        for (int i = 0; i < n; i++) begin
            int w;
            while (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
                pix_valid = 1'b0;
                @(posedge clk); #1;
            end
            pix_valid = 1'b1;
            pix_data = ramp ? 8'(i) : 8'($urandom);
            w = 0;
            @(negedge clk);
            while (!pix_ready && w < TMO) begin
                @(negedge clk);
                w++;
            end
            @(posedge clk); #1;
            if (w >= TMO) begin
                checks++;
                errors++;
                $display("FAIL %s pix_ready: got 0 for %0d cycles at pixel %0d, want 1", tag, TMO, i);
                pix_valid = 1'b0;
                return;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_frame_done(input string tag);
        int n = 0;
        while (fd_cyc.size() == 0 && n < 4 * TMO) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (fd_cyc.size() == 0) begin
            errors++;
            $display("FAIL %s frame_done: none within %0d cycles, want one pulse", tag, n);
        end
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        logic [28:0] v;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        v = {pix_ready, eng_start, eng_pixel, blk_idx, busy, frame_done, err};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL reset_in outputs: got %h, want 0", v);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        v = {pix_ready, eng_start, eng_pixel, blk_idx, busy, frame_done, err};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL reset_idle outputs: got %h, want 0", v);
        end
    endtask

    task automatic test_single_block();
        int f;
        clear_logs();
        eng_lat_min = 20; eng_lat_max = 40; eng_ncoef = 64;
        start_frame(1, f);
        send_pixels(64, 1'b1, 0, "single");
        wait_frame_done("single");
        checks++;
        if (hs_cyc.size() !== 64 || hs_cyc[0] !== f + 1) begin
            errors++;
            $display("FAIL single first_handshake: got %0d hs, first at %0d, want 64 at %0d", hs_cyc.size(), (hs_cyc.size() > 0) ? hs_cyc[0] : -1, f + 1);
        end
        checks++;
        if (start_cyc.size() !== 1) begin
            errors++;
            $display("FAIL single start_count: got %0d, want 1", start_cyc.size());
        end else begin
            checks++;
            if (start_cyc[0] !== hs_cyc[63] + 2) begin
                errors++;
                $display("FAIL single start_cycle: got %0d, want %0d", start_cyc[0], hs_cyc[63] + 2);
            end
        end
        checks++;
        if (pix_err !== 0 || pix_cnt !== 64) begin
            errors++;
            $display("FAIL single pixel_stream: got %0d bad of %0d, want 0 of 64", pix_err, pix_cnt);
        end
        checks++;
        if (fd_cyc.size() !== 1 || done_cyc.size() !== 1 || fd_cyc[0] !== done_cyc[0] + 1 || busy_at_fd[0] !== 1'b0) begin
            errors++;
            $display("FAIL single frame_done: got %0d pulses, %0d dones, want 1 pulse one cycle after done with busy 0", fd_cyc.size(), done_cyc.size());
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL single err: got %b, want 0", err);
        end
    endtask

    task automatic test_back_pressure();
        int f;
        clear_logs();
        eng_lat_min = 400; eng_lat_max = 400; eng_ncoef = 64;
        start_frame(3, f);
        send_pixels(192, 1'b0, 0, "bp");
        wait_frame_done("bp");
        checks++;
        if (hs_cyc.size() !== 192 || done_cyc.size() !== 3) begin
            errors++;
            $display("FAIL bp counts: got %0d hs %0d dones, want 192 and 3", hs_cyc.size(), done_cyc.size());
        end else begin
            checks++;
            if (hs_cyc[127] - hs_cyc[0] !== 127) begin
                errors++;
                $display("FAIL bp two_bank_fill: got span %0d, want 127", hs_cyc[127] - hs_cyc[0]);
            end
            checks++;
            if (hs_cyc[128] !== done_cyc[0] + 1) begin
                errors++;
                $display("FAIL bp ready_resume: got %0d, want %0d", hs_cyc[128], done_cyc[0] + 1);
            end
        end
        checks++;
        if (start_blk.size() !== 3) begin
            errors++;
            $display("FAIL bp start_count: got %0d, want 3", start_blk.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (start_blk[i] !== NB_W'(i)) begin
                    errors++;
                    $display("FAIL bp blk_idx[%0d]: got %0d, want %0d", i, start_blk[i], i);
                end
            end
            checks++;
            if (done_cyc.size() < 1 || start_cyc[1] < done_cyc[0] + 2) begin
                errors++;
                $display("FAIL bp restart_gap: got start %0d, want >= done+2", start_cyc[1]);
            end
        end
        checks++;
        if (fd_cyc.size() !== 1 || pix_err !== 0 || pix_cnt !== 192 || err !== 1'b0) begin
            errors++;
            $display("FAIL bp completion: got fd=%0d bad=%0d cnt=%0d err=%b, want 1 0 192 0", fd_cyc.size(), pix_err, pix_cnt, err);
        end
    endtask

    task automatic test_random_frames();
        for (int it = 0; it < 4; it++) begin
            int f;
            int cfg;
            cfg = int'($urandom_range(4, 1));
            clear_logs();
            eng_lat_min = 10; eng_lat_max = 80; eng_ncoef = 64;
            start_frame(cfg, f);
            send_pixels(64 * cfg, 1'b0, 30, "rand");
            wait_frame_done("rand");
            checks++;
            if (start_cyc.size() !== cfg || blk_idx !== NB_W'(cfg)) begin
                errors++;
                $display("FAIL rand%0d blocks: got starts=%0d blk_idx=%0d, want %0d", it, start_cyc.size(), blk_idx, cfg);
            end
            checks++;
            if (fd_cyc.size() !== 1 || done_cyc.size() == 0 || fd_cyc[0] !== done_cyc[done_cyc.size() - 1] + 1) begin
                errors++;
                $display("FAIL rand%0d frame_done: got %0d pulses, want 1 right after last done", it, fd_cyc.size());
            end
            checks++;
            if (pix_err !== 0 || pix_cnt !== 64 * cfg || err !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d stream: got bad=%0d cnt=%0d err=%b busy=%b, want 0 %0d 0 0", it, pix_err, pix_cnt, err, busy, 64 * cfg);
            end
        end
    endtask

    task automatic test_zero_blocks();
        int f;
        clear_logs();
        pix_valid = 1'b1;
        start_frame(0, f);
        repeat (20) begin @(posedge clk); #1; end
        pix_valid = 1'b0;
        checks++;
        if (fd_cyc.size() !== 1 || fd_cyc[0] !== f + 1) begin
            errors++;
            $display("FAIL zero frame_done: got %0d pulses first at %0d, want 1 at %0d", fd_cyc.size(), (fd_cyc.size() > 0) ? fd_cyc[0] : -1, f + 1);
        end
        checks++;
        if (ready_seen !== 1'b0 || busy_seen !== 1'b0 || hs_cyc.size() !== 0) begin
            errors++;
            $display("FAIL zero idle: got ready=%b busy=%b hs=%0d, want 0 0 0", ready_seen, busy_seen, hs_cyc.size());
        end
    endtask

    task automatic test_count_error();
        int f;
        clear_logs();
        eng_lat_min = 10; eng_lat_max = 30; eng_ncoef = 63;
        start_frame(1, f);
        send_pixels(64, 1'b0, 0, "cnt");
        wait_frame_done("cnt");
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL cnt err_sticky: got %b, want 1", err);
        end
        clear_logs();
        eng_ncoef = 64;
        start_frame(1, f);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL cnt err_clear: got %b, want 0", err);
        end
        send_pixels(64, 1'b0, 0, "cnt2");
        wait_frame_done("cnt2");
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL cnt clean_frame err: got %b, want 0", err);
        end
        @(negedge clk) eng_done = 1'b1;
        @(negedge clk) eng_done = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL cnt stray_done err: got %b, want 1", err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignored_restart();
        int f;
        clear_logs();
        eng_lat_min = 10; eng_lat_max = 40; eng_ncoef = 64;
        start_frame(2, f);
        send_pixels(64, 1'b0, 10, "ign");
        start_frame(5, f);
        send_pixels(64, 1'b0, 10, "ign");
        wait_frame_done("ign");
        checks++;
        if (start_cyc.size() !== 2 || fd_cyc.size() !== 1 || blk_idx !== NB_W'(2) || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL ign frame: got starts=%0d fd=%0d blk_idx=%0d busy=%b err=%b, want 2 1 2 0 0", start_cyc.size(), fd_cyc.size(), blk_idx, busy, err);
        end
        ready_seen = 0;
        pix_valid = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        pix_valid = 1'b0;
        checks++;
        if (ready_seen !== 1'b0 || hs_cyc.size() !== 128 || pix_err !== 0) begin
            errors++;
            $display("FAIL ign extra_pixels: got ready=%b hs=%0d bad=%0d, want 0 128 0", ready_seen, hs_cyc.size(), pix_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        int f;
        int n;
        logic [28:0] v;
        clear_logs();
        eng_lat_min = 20; eng_lat_max = 40; eng_ncoef = 64;
        start_frame(3, f);
        send_pixels(128, 1'b0, 0, "rst");
        n = 0;
        while (start_cyc.size() < 2 && n < TMO) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (start_cyc.size() < 2) begin
            errors++;
            $display("FAIL rst second_start: got %0d starts, want 2", start_cyc.size());
        end
        repeat (10) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        v = {pix_ready, eng_start, eng_pixel, blk_idx, busy, frame_done, err};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL rst async_outputs: got %h, want 0", v);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        start_frame(1, f);
        send_pixels(64, 1'b1, 20, "rst2");
        wait_frame_done("rst2");
        checks++;
        if (start_cyc.size() !== 1 || fd_cyc.size() !== 1 || blk_idx !== NB_W'(1) || err !== 1'b0 || pix_err !== 0 || pix_cnt !== 64) begin
            errors++;
            $display("FAIL rst fresh_frame: got starts=%0d fd=%0d blk_idx=%0d err=%b bad=%0d cnt=%0d, want 1 1 1 0 0 64", start_cyc.size(), fd_cyc.size(), blk_idx, err, pix_err, pix_cnt);
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_single_block();
        test_back_pressure();
        test_random_frames();
        test_zero_blocks();
        test_count_error();
        test_ignored_restart();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "time limit");
    end

endmodule
